// File: rtl/demux_mem_writer_pkg.sv
// Shared definitions for the demux memory writer and the memory-transfer controller:
// default widths and the transfer FSM state encoding.
package demux_mem_writer_pkg;

  localparam int DMW_DW = 8;
  localparam int DMW_AW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/demux_mem_writer_addr_counter.sv
// Write-address and remaining-word counter for one transfer.
// Loads on start, steps on every accepted word, and flags the final word.
module dmw_addr_counter
  import demux_mem_writer_pkg::*;
#(
  parameter int AW = DMW_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [AW-1:0] load_len,
  input  logic          accept,
  output logic [AW-1:0] addr,
  output logic          last
);

  // One extra bit so a zero length can stand for a full 2^AW-word transfer.
  logic [AW:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= (load_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, load_len};
    end else if (accept && remaining != '0) begin
      addr      <= addr + AW'(1);
      remaining <= remaining - (AW + 1)'(1);
    end
  end

  assign last = (remaining == (AW + 1)'(1));

endmodule

// File: rtl/demux_mem_writer.sv
// Streams a counted block of words into one of two memories, chosen at start,
// with a registered write port shared by both memories.
module demux_mem_writer
  import demux_mem_writer_pkg::*;
#(
  parameter int DW = DMW_DW,
  parameter int AW = DMW_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dst_sel,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          we_a,
  output logic          we_b,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done
);

  logic [1:0]    state;
  logic          sel;
  logic          load;
  logic          accept;
  logic          last;
  logic [AW-1:0] addr;

  // Handshake flags come from the state register only, never from in_valid.
  assign in_ready = (state == ST_XFER);
  assign busy     = (state == ST_XFER) || (state == ST_DONE);
  assign done     = (state == ST_DONE);
  assign load     = (state == ST_IDLE) && start;
  assign accept   = in_ready && in_valid;

  dmw_addr_counter #(.AW(AW)) u_addr_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_addr (base_addr),
    .load_len  (len),
    .accept    (accept),
    .addr      (addr),
    .last      (last)
  );

  // Strobes default low each cycle; address and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      we_a  <= 1'b0;
      we_b  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we_a <= 1'b0;
      we_b <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel   <= dst_sel;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            wdata <= in_data;
            waddr <= addr;
            we_a  <= ~sel;
            we_b  <= sel;
            if (last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_mem_writer.sv
// Directed self-checking bench for demux_mem_writer: write log captured on the
// falling edge and compared against hand-computed addresses, data and targets.
module tb_demux_mem_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dst_sel = 1'b0;
  logic [3:0] base_addr = '0;
  logic [3:0] len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       we_a;
  logic       we_b;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;

  int assertCount = 0;
  int failCount = 0;

  logic [3:0] wrAddr[$];
  logic [7:0] wrData[$];
  logic       wrSel[$];
  int readyCnt;
  int doneCnt;
  int doneWithStrobe;
  int bothCnt;

  demux_mem_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dst_sel   (dst_sel),
    .base_addr (base_addr),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .we_a      (we_a),
    .we_b      (we_b),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Monitor samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (we_a || we_b) begin
      wrAddr.push_back(waddr);
      wrData.push_back(wdata);
      wrSel.push_back(we_b);
    end
    if (we_a && we_b) bothCnt++;
    if (in_ready) readyCnt++;
    if (done) doneCnt++;
    if (done && (we_a || we_b)) doneWithStrobe++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrSel.delete();
    readyCnt = 0;
    doneCnt = 0;
    doneWithStrobe = 0;
    bothCnt = 0;
  endtask

  // Compare the captured writes with an expected run of consecutive addresses
  // carrying consecutive data values.
  task automatic checkWrites(input string tag, input int nWrites, input logic sel,
                             input logic [3:0] firstAddr, input logic [7:0] firstData);
    logic [3:0] expAddr;
    logic [7:0] expData;
    checkOutput({tag, " write count"}, wrAddr.size(), nWrites);
    expAddr = firstAddr;
    expData = firstData;
    for (int i = 0; i < nWrites && i < wrAddr.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), wrAddr[i], expAddr);
      checkOutput($sformatf("%s data[%0d]", tag, i), wrData[i], expData);
      checkOutput($sformatf("%s target[%0d]", tag, i), wrSel[i], sel);
      expAddr = expAddr + 4'd1;
      expData = expData + 8'd1;
    end
    checkOutput({tag, " both strobes"}, bothCnt, 0);
  endtask

  // One complete transfer: start pulse, words with optional invalid gaps,
  // optional start during XFER (at word restartAt) and in the DONE cycle.
  task automatic applyStimulus(input logic sel, input logic [3:0] base, input logic [3:0] n,
                               input logic [7:0] d0, input int gap, input int restartAt,
                               input bit startInDone);
    int words;
    words = (n == 4'd0) ? 16 : int'(n);
    @(posedge clk); #1;
    start = 1'b1; dst_sel = sel; base_addr = base; len = n;
    @(posedge clk); #1;
    start = 1'b0; dst_sel = ~sel; base_addr = base + 4'd7; len = n + 4'd1;
    for (int i = 0; i < words; i++) begin
      in_valid = 1'b1;
      in_data = d0 + 8'(i);
      if (i == restartAt) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 8'hEE;
      if (i != words - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
    end
    if (startInDone) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clearLog();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset we", {we_a, we_b}, 0);
    checkOutput("reset busy/done", {busy, done}, 0);
    checkOutput("reset waddr", waddr, 0);
    checkOutput("reset wdata", wdata, 0);
    rst_n = 1'b1;

    clearLog();
    applyStimulus(1'b0, 4'd2, 4'd3, 8'h01, 0, -1, 1'b0);
    checkWrites("basic", 3, 1'b0, 4'd2, 8'h01);
    checkOutput("basic ready cycles", readyCnt, 3);
    checkOutput("basic done pulses", doneCnt, 1);
    checkOutput("basic done with strobe", doneWithStrobe, 1);
    checkOutput("basic hold waddr", waddr, 4);
    checkOutput("basic hold wdata", wdata, 8'h03);
    checkOutput("basic idle busy", busy, 0);

    clearLog();
    applyStimulus(1'b1, 4'd14, 4'd4, 8'h10, 0, -1, 1'b0);
    checkWrites("wrap", 4, 1'b1, 4'd14, 8'h10);
    checkOutput("wrap last addr", wrAddr.size() == 4 ? wrAddr[3] : 4'hF, 4'd1);
    checkOutput("wrap done pulses", doneCnt, 1);

    clearLog();
    applyStimulus(1'b0, 4'd0, 4'd0, 8'h40, 0, -1, 1'b0);
    checkWrites("full", 16, 1'b0, 4'd0, 8'h40);
    checkOutput("full ready cycles", readyCnt, 16);
    checkOutput("full done pulses", doneCnt, 1);

    clearLog();
    applyStimulus(1'b0, 4'd5, 4'd2, 8'hA0, 3, -1, 1'b0);
    checkWrites("gap", 2, 1'b0, 4'd5, 8'hA0);
    checkOutput("gap ready cycles", readyCnt, 5);
    checkOutput("gap done with strobe", doneWithStrobe, 1);

    clearLog();
    applyStimulus(1'b0, 4'd8, 4'd3, 8'h70, 0, 1, 1'b1);
    checkWrites("restart", 3, 1'b0, 4'd8, 8'h70);
    checkOutput("restart ready cycles", readyCnt, 3);
    checkOutput("restart done pulses", doneCnt, 1);
    checkOutput("restart idle busy", busy, 0);

    // Reset after the second of five accepted words.
    clearLog();
    @(posedge clk); #1;
    start = 1'b1; dst_sel = 1'b1; base_addr = 4'd3; len = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h30;
    @(posedge clk); #1;
    in_data = 8'h31;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst in_ready", in_ready, 0);
    checkOutput("midrst we", {we_a, we_b}, 0);
    checkOutput("midrst busy/done", {busy, done}, 0);
    checkOutput("midrst waddr", waddr, 0);
    checkOutput("midrst wdata", wdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_data = 8'h55;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkWrites("midrst", 1, 1'b1, 4'd3, 8'h30);
    checkOutput("midrst ready cycles", readyCnt, 2);
    checkOutput("midrst done pulses", doneCnt, 0);

    clearLog();
    applyStimulus(1'b0, 4'd9, 4'd2, 8'hC0, 0, -1, 1'b0);
    checkWrites("postrst", 2, 1'b0, 4'd9, 8'hC0);
    checkOutput("postrst done pulses", doneCnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/demux_mem_writer.md
DEMUX_MEM_WRITER -- requirements
Module: demux_mem_writer

Interface
REQ-001 Parameter DW, default 8, data word width in bits.
REQ-002 Parameter AW, default 4, destination memory address width in bits.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle request to begin a transfer; sampled in IDLE only.
REQ-006 dst_sel  in  1  destination select, sampled with start: 0 selects memory A, 1 selects memory B.
REQ-007 base_addr  in  AW  first write address, sampled with start.
REQ-008 len  in  AW  word count, sampled with start; 0 means 2^AW words.
REQ-009 in_data  in  DW  source word, paired with in_valid.
REQ-010 in_valid  in  1  source word present.
REQ-011 in_ready  out  1  block accepts a word this cycle.
REQ-012 we_a, we_b  out  1 each  write strobes for memory A and memory B.
REQ-013 waddr  out  AW  write address shared by both memories.
REQ-014 wdata  out  DW  write data shared by both memories.
REQ-015 busy  out  1  high in XFER and DONE.
REQ-016 done  out  1  one-cycle pulse at transfer completion.

Function
REQ-017 FSM SHALL have states IDLE, XFER and DONE.
- IDLE->XFER on start.
- XFER->DONE on the cycle the final word is accepted.
- DONE->IDLE unconditionally after one cycle.
REQ-018 On start in IDLE, the block SHALL latch dst_sel, base_addr and len into internal registers.
- The latched length is len, or 2^AW when len is 0.
- The address counter loads base_addr.
- The remaining-word counter loads the latched length.
REQ-019 in_ready SHALL be 1 exactly when the state is XFER, decoded from the state register only (no combinational path from in_valid).
REQ-020 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_valid low inserts wait cycles with no write.
REQ-021 Writes SHALL be registered with 1-cycle latency.
- In the cycle after an accept, wdata equals the accepted in_data and waddr equals the current address.
- we_a is 1 when the latched dst_sel is 0; otherwise we_b is 1.
REQ-022 we_a and we_b SHALL never be 1 in the same cycle and SHALL be 0 in every cycle that does not follow an accept.
REQ-023 The address SHALL increment by 1 per accepted word, wrapping modulo 2^AW (for AW=4, address 15 is followed by 0).
REQ-024 After the last accept, in_ready SHALL be 0 from the next cycle; the last write strobe and done SHALL both be asserted in the DONE cycle.
REQ-025 start SHALL be ignored while busy is 1; dst_sel, base_addr and len SHALL NOT affect an ongoing transfer.
REQ-026 start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; start is honoured only when the state register is IDLE.
REQ-027 wdata and waddr SHALL hold their last values when no strobe is active.

Reset
REQ-028 When rst_n is low, the block SHALL asynchronously force:
- state to IDLE;
- in_ready, we_a, we_b, busy and done to 0;
- waddr, wdata and all counters to 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no further strobes; the first action after rst_n rises is a new start.

Structure
REQ-030 The state encoding and the DW/AW defaults SHALL live in the project shared definitions package; the memory-transfer controller reuses them.
REQ-031 The address/remaining-count logic SHALL be one sub-module, dmw_addr_counter: load, decrement-and-increment on accept, last-word flag.
REQ-032 The FSM, the demux decode and the write register SHALL be in the top module.

Verification
REQ-033 start, dst_sel=0, base_addr=2, len=3, in_valid held high with data 8'h01, 8'h02, 8'h03 -> we_a pulses at addresses 2, 3, 4 with those data; we_b stays 0; done pulses once; in_ready is high for exactly 3 cycles.
REQ-034 dst_sel=1, base_addr=14, len=4, data 8'h10..8'h13 -> we_b writes at addresses 14, 15, 0, 1 (wrap-around); we_a stays 0.
REQ-035 len=0, base_addr=0 -> exactly 16 writes at addresses 0..15, then done.
REQ-036 len=2 with in_valid low for 3 cycles between words -> no strobes during the gap; exactly 2 writes; done follows the second accept.
REQ-037 start pulsed during XFER with dst_sel flipped -> ignored; the transfer completes to the original memory. start pulsed in the DONE cycle -> no new transfer.
REQ-038 rst_n driven low after the 2nd of 5 words -> all outputs are 0 immediately; after release, no strobes occur until a new start, and the new transfer runs correctly.
